// File: rtl/min_sec_counter.sv
// Seconds/minutes BCD counter (00:00-59:59) with a 1 Hz prescaler, run/pause/idle
// control and manual minute setting; hour_inc feeds the downstream hour counter.
module min_sec_counter #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       clear,
  input  logic       set_min,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       tick_1hz,
  output logic       hour_inc,
  output logic       running
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  state_t             state, state_nxt;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               so_wrap, st_wrap, mo_wrap, mt_wrap;
  logic               sec_carry, min_adv;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // stop outranks start_resume in every state, even where stop itself is a no-op
  always_comb begin
    state_nxt = state;
    if (clear)
      state_nxt = IDLE;
    else if (state == RUN) begin
      if (stop) state_nxt = PAUSE;
    end else if (!stop && start_resume)
      state_nxt = RUN;
  end

  assign running = (state == RUN);
  assign tick    = (state == RUN) && (presc == PRESC_MAX);

  // >= comparisons let an out-of-range digit fall back to 0 on its next step
  assign so_wrap   = (sec_ones >= 4'd9);
  assign st_wrap   = (sec_tens >= 3'd5);
  assign mo_wrap   = (min_ones >= 4'd9);
  assign mt_wrap   = (min_tens >= 3'd5);
  assign sec_carry = so_wrap && st_wrap;
  assign min_adv   = (tick && sec_carry) || ((state != RUN) && set_min);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc    <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
      tick_1hz <= 1'b0;
      hour_inc <= 1'b0;
    end else begin
      tick_1hz <= tick;
      hour_inc <= tick && sec_carry && mo_wrap && mt_wrap;

      if (state == RUN)
        presc <= tick ? '0 : presc + 1'b1;
      else if (state == IDLE)
        presc <= '0;

      if (tick) begin
        sec_ones <= so_wrap ? 4'd0 : sec_ones + 4'd1;
        if (so_wrap)
          sec_tens <= st_wrap ? 3'd0 : sec_tens + 3'd1;
      end

      if (min_adv) begin
        min_ones <= mo_wrap ? 4'd0 : min_ones + 4'd1;
        if (mo_wrap)
          min_tens <= mt_wrap ? 3'd0 : min_tens + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_min_sec_counter.sv
// Directed + random bench for min_sec_counter; reference model tracks elapsed
// seconds as a plain integer and checks every output every cycle.
module tb_min_sec_counter;
  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset, start_resume, stop, clear, set_min;
  logic [3:0] sec_ones, min_ones;
  logic [2:0] sec_tens, min_tens;
  logic       tick_1hz, hour_inc, running;

  min_sec_counter #(.TICKS_PER_SEC(TPS), .PRESC_W(3)) dut (
    .clk(clk), .reset(reset), .start_resume(start_resume), .stop(stop),
    .clear(clear), .set_min(set_min), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .tick_1hz(tick_1hz),
    .hour_inc(hour_inc), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  // model: m_t = elapsed seconds 0..3599, m_p = cycles into current second, m_st 0 idle/1 run/2 pause
  int m_t, m_p, m_st, m_tick, m_hr;
  int hr_pulses = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit sr, input bit sp, input bit cl, input bit sm);
    if (r || cl) begin
      m_t = 0; m_p = 0; m_st = 0; m_tick = 0; m_hr = 0;
    end else begin
      m_tick = 0; m_hr = 0;
      if (m_st == 1) begin
        if (m_p == TPS - 1) begin
          m_p = 0; m_tick = 1;
          if (m_t == 3599) m_hr = 1;
          m_t = (m_t + 1) % 3600;
        end else m_p++;
      end
      if (m_st != 1 && sm) m_t = (((m_t / 60) + 1) % 60) * 60 + m_t % 60;
      if (m_st == 1 && sp) m_st = 2;
      else if (m_st != 1 && !sp && sr) m_st = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit sr, input bit sp, input bit cl, input bit sm);
    int got_digits, exp_digits;
    @(negedge clk);
    reset = r; start_resume = sr; stop = sp; clear = cl; set_min = sm;
    model_step(r, sr, sp, cl, sm);
    @(posedge clk);
    #1;
    got_digits = min_tens * 1000 + min_ones * 100 + sec_tens * 10 + sec_ones;
    exp_digits = (m_t / 60) * 100 + (m_t % 60);
    chk("digits", got_digits, exp_digits);
    chk("tick_1hz", tick_1hz, m_tick);
    chk("hour_inc", hour_inc, m_hr);
    chk("running", running, (m_st == 1) ? 1 : 0);
    if (hour_inc) hr_pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    reset = 1; start_resume = 0; stop = 0; clear = 0; set_min = 0;
    m_t = 0; m_p = 0; m_st = 0; m_tick = 0; m_hr = 0;

    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    // start, ticks at 4/8/12, then through 00:59 -> 01:00
    cyc(0, 1, 0, 0, 0);
    idle(12);
    chk("sec_after_3_ticks", sec_ones, 3);
    idle(57 * TPS);
    chk("at_01_00", {28'd0, min_ones}, 1);

    // 59:00 by set_min, then 60 ticks to the hour wrap
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 0, 1);
    hr_pulses = 0;
    cyc(0, 1, 0, 0, 0);
    idle(60 * TPS + 2);
    chk("hour_pulse_count", hr_pulses, 1);

    // pause mid-second: stop when two cycles past a tick
    guard = 0;
    while (m_p != 1 && guard < 20) begin idle(1); guard++; end
    chk("sync_guard", guard < 20, 1);
    cyc(0, 0, 1, 0, 0);
    idle(10);
    cyc(0, 1, 0, 0, 0);
    idle(2);
    chk("tick_after_resume", tick_1hz, 1);

    // stop + start together -> pause
    cyc(0, 1, 1, 0, 0);
    chk("stop_wins", running, 0);

    // set_min in RUN ignored at 00:07
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    idle(7 * TPS);
    cyc(0, 0, 0, 0, 1);
    // set_min in PAUSE at 59:30 -> 00:30
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    idle(30 * TPS);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("pause_setmin_wrap", m_t, 30);

    // clear at 12:34 mid-run
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    idle(34 * TPS);
    cyc(0, 0, 0, 1, 0);

    // reset on the very edge that would wrap the hour
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    guard = 0;
    while (!(m_t == 3599 && m_p == TPS - 1) && guard < 400) begin idle(1); guard++; end
    chk("wrap_guard", guard < 400, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // random pulses
    for (int i = 0; i < 4000; i++)
      cyc(($urandom % 400) == 0, ($urandom % 20) == 0, ($urandom % 30) == 0,
          ($urandom % 300) == 0, ($urandom % 4) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/min_sec_counter.md
Name: min_sec_counter

Overview:
- Upstream stage of the watch hour counter: divides clk to a 1 Hz tick and counts seconds and minutes as BCD digits, 00:00 to 59:59.
- Emits a one-cycle hour_inc pulse on the 59:59 -> 00:00 rollover; this pulse drives the hour counter's advance input.
- Contains a run/pause/idle control FSM driven by start_resume, stop and clear pulses.
- Also supports manual minute setting while not running.

Parameters:
- TICKS_PER_SEC, 50000000: clk cycles per second tick; must be >= 2.
- PRESC_W, 26: prescaler counter width; must satisfy 2**PRESC_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clock clk
- start_resume  input  1  single-cycle pulse: start or resume counting
- stop  input  1  single-cycle pulse: pause counting
- clear  input  1  single-cycle pulse: zero all counts, return to IDLE
- set_min  input  1  single-cycle pulse: advance minutes by 1 (IDLE/PAUSE only)
- sec_ones  output  4  seconds units digit, BCD 0-9
- sec_tens  output  3  seconds tens digit, 0-5
- min_ones  output  4  minutes units digit, BCD 0-9
- min_tens  output  3  minutes tens digit, 0-5
- tick_1hz  output  1  one-cycle pulse on every seconds increment
- hour_inc  output  1  one-cycle pulse on 59:59 -> 00:00 wrap
- running  output  1  high while FSM is in RUN

Behaviour:
- Reset (reset=1 at a clk edge):
  - all digits 0, prescaler 0;
  - tick_1hz=0, hour_inc=0, running=0;
  - FSM -> IDLE.
  - Reset overrides every other input.
- FSM states: IDLE, RUN, PAUSE. Input priority: reset > clear > stop > start_resume.
  - clear (any state): digits 0, prescaler 0, next state IDLE, no pulses.
  - stop: RUN -> PAUSE. Ignored in IDLE and PAUSE.
  - start_resume: IDLE -> RUN, PAUSE -> RUN. Ignored in RUN.
  - stop and start_resume in the same cycle: stop wins.
- Prescaler:
  - increments only while the current state is RUN;
  - at value TICKS_PER_SEC-1 it wraps to 0 and the seconds counter advances at the same edge;
  - holds its value in PAUSE, so a resumed second completes the remaining cycles only;
  - is zeroed in IDLE.
- First tick after start from IDLE occurs exactly TICKS_PER_SEC cycles after the start_resume edge.
- Counting (registered, on the tick edge):
  - sec_ones 9 -> 0 with sec_tens +1;
  - seconds 59 -> 00 with minutes +1;
  - min_ones 9 -> 0 with min_tens +1;
  - minutes 59 -> 00 asserts hour_inc.
- tick_1hz and hour_inc:
  - both registered, high for exactly one cycle;
  - assert in the same cycle the digits first show the new value.
  - hour_inc occurs only on the 59:59 wrap in RUN.
- A tick edge where stop is also asserted is still counted, because the current state is RUN; pausing takes effect from the next cycle.
- set_min:
  - honoured only when the current state is IDLE or PAUSE;
  - minutes +1 mod 60, seconds and prescaler unchanged;
  - never asserts hour_inc or tick_1hz;
  - ignored in RUN, and ignored if clear or reset is asserted in the same cycle;
  - if start_resume arrives in the same cycle, set_min still applies because the current state is not RUN.
- Digits are never outside BCD range. Illegal digit values (not reachable) recover to 0 on the next increment.
- Latency: input pulse -> state/output change at the next clk edge. running reflects the registered state.

Test Plan (TICKS_PER_SEC=4):
- Reset then start_resume pulse -> running=1 next cycle. tick_1hz at cycles 4, 8, 12 after the start edge; sec_ones=1, 2, 3.
- Run to 00:59, then one more tick -> digits 01:00. tick_1hz=1 and hour_inc=0 that cycle.
- set_min x59 in IDLE (reaching 59:00), start_resume, run 60 ticks -> digits 00:00. hour_inc=1 for exactly one cycle, coincident with the wrap; tick_1hz=1 same cycle.
- Run 2 cycles past a tick, stop for 10 cycles, then start_resume -> next tick arrives 2 cycles after the resume edge, and the digits do not change during the pause.
- stop and start_resume together in RUN -> PAUSE, running=0. set_min in RUN at 00:07 -> minutes unchanged. set_min in PAUSE at 59:30 -> 00:30, hour_inc=0.
- clear mid-run at 12:34 -> 00:00 and IDLE next cycle. reset asserted concurrently with tick and hour wrap -> all outputs 0, no pulses.
